cba_pipe_adder: RTL

Parametrised, pipelined carry-bypass adder/subtractor. It generalises the 4-bit carry-bypass cell to WIDTH bits split into BLOCK-bit bypass blocks, with a register stage after every BLK_PER_STAGE blocks. A valid/ready handshake on input and output provides full backpressure. It sits in the datapath library as the throughput-oriented adder for wide operands.

---
 rtl/cba_pipe_adder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cba_pipe_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cba_pipe_adder: pipelined carry-bypass adder/subtractor, valid/ready I/O |
// | Optional macro CBA_SUB_EN enables the sub input.   Revision: 1.0        |
// +--------------------------------------------------------------------------+
module cba_pipe_adder #(
  parameter int WIDTH         = 16,
  parameter int BLOCK         = 4,
  parameter int BLK_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int L    = NBLK / BLK_PER_STAGE;
  localparam int SW   = BLOCK * BLK_PER_STAGE;

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

`ifdef CBA_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? 1'b1 : cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff      = b;
  assign c0         = cin;
`endif

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  // Each stage owns its input registers: operands still to be added, carry-in,
  // the low sum bits already resolved upstream, and a valid bit.
  for (genvar k = 0; k < L; k++) begin : g_stage
    localparam int RW = WIDTH - k * SW;

    logic [RW-1:0]         a_q, b_q, a_d, b_d;
    logic                  c_q, c_d;
    logic                  v_q, v_d;
    logic [SW-1:0]         s_w;
    logic                  co_w;
    logic [(k+1)*SW-1:0]   acc_w;

    if (k == 0) begin : g_src
      assign a_d = a;
      assign b_d = b_eff;
      assign c_d = c0;
      assign v_d = in_valid;
    end else begin : g_src
      assign a_d = g_stage[k-1].a_q[RW+SW-1:SW];
      assign b_d = g_stage[k-1].b_q[RW+SW-1:SW];
      assign c_d = g_stage[k-1].co_w;
      assign v_d = g_stage[k-1].v_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q <= '0;
        b_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (en) begin
        a_q <= a_d;
        b_q <= b_d;
        c_q <= c_d;
        v_q <= v_d;
      end
    end

    always_comb begin : p_blocks
      logic [BLOCK-1:0] x_blk;
      logic             c_blk;
      logic             c_rip;
      s_w   = '0;
      c_blk = c_q;
      for (int j = 0; j < BLK_PER_STAGE; j++) begin
        x_blk = a_q[j*BLOCK +: BLOCK] ^ b_q[j*BLOCK +: BLOCK];
        c_rip = c_blk;
        for (int t = 0; t < BLOCK; t++) begin
          s_w[j*BLOCK+t] = x_blk[t] ^ c_rip;
          c_rip          = (a_q[j*BLOCK+t] & b_q[j*BLOCK+t]) | (x_blk[t] & c_rip);
        end
        // Bypass mux: a fully propagating block forwards its carry-in.
        c_blk = (&x_blk) ? c_blk : c_rip;
      end
      co_w = c_blk;
    end

    if (k == 0) begin : g_acc
      assign acc_w = s_w;
    end else begin : g_acc
      logic [k*SW-1:0] s_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s_q <= '0;
        end else if (en) begin
          s_q <= g_stage[k-1].acc_w;
        end
      end
      assign acc_w = {s_w, s_q};
    end
  end

  assign sum_d  = g_stage[L-1].acc_w;
  assign cout_d = g_stage[L-1].co_w;
  assign ovf_d  = (g_stage[L-1].a_q[SW-1] == g_stage[L-1].b_q[SW-1]) &&
                  (g_stage[L-1].s_w[SW-1] != g_stage[L-1].a_q[SW-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= g_stage[L-1].v_q;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire
